// File: rtl/mem_pkg.sv
// Shared types and constants for the word-organised memory responder.
// Size codes follow the datapath's size-adjust encoding; code 3 behaves as a word.
package mem_pkg;

  localparam int DEFAULT_DEPTH_LOG2 = 8;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  typedef enum logic {
    ST_IDLE,
    ST_RMW
  } state_t;

  // Halfword and byte stores need the read-modify-write pass; everything else is a word.
  function automatic logic is_subword(input logic [1:0] sz);
    return (sz == SZ_HALF) || (sz == SZ_BYTE);
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Big-endian sub-word merge: drops right-aligned store data into the addressed
// lane of an old word and reports which bytes changed.
module lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_new_data,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  output logic [31:0] o_merged,
  output logic [3:0]  o_byte_en
);

  logic [31:0] w_rep;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    w_rep     = i_new_data;
    o_byte_en = 4'b1111;
    o_merged  = i_old_word;
    case (i_size)
      SZ_HALF: begin
        w_rep     = {2{i_new_data[15:0]}};
        o_byte_en = i_lane[1] ? 4'b0011 : 4'b1100;
      end
      SZ_BYTE: begin
        w_rep     = {4{i_new_data[7:0]}};
        o_byte_en = 4'b1000 >> i_lane;   // lane 0 is the most significant byte
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (o_byte_en[i]) o_merged[8*i +: 8] = w_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: reads return two cycles after the address,
// word stores commit in one cycle, sub-word stores take an internal RMW cycle.
module mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_LOG2  = DEFAULT_DEPTH_LOG2,
  parameter logic [31:0] RESET_RDATA = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic [1:0]  size,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // NOTE: the array has no reset; contents survive rst and only control state is cleared.
  logic [31:0] r_mem [DEPTH];

  state_t                r_state, w_next_state;
  logic [DEPTH_LOG2-1:0] w_idx, r_idx, w_wr_idx;
  logic [1:0]            r_lane, r_size;
  logic [31:0]           r_wdata, r_rd_q1, r_rd_q2;
  logic [31:0]           w_merged, w_wr_data;
  logic [3:0]            w_lane_be, w_wr_be;
  logic                  w_we;
  logic                  w_unused;

  assign w_idx    = addr[DEPTH_LOG2+1:2];
  assign w_unused = ^addr[31:DEPTH_LOG2+2];   // high address bits alias by design

  lane_merge u_lane_merge (
    .i_old_word (r_mem[r_idx]),
    .i_new_data (r_wdata),
    .i_size     (r_size),
    .i_lane     (r_lane),
    .o_merged   (w_merged),
    .o_byte_en  (w_lane_be)
  );

  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    w_wr_idx     = w_idx;
    w_wr_data    = wdata;
    w_wr_be      = 4'b1111;
    case (r_state)
      ST_IDLE: begin
        if (mem_write) begin
          if (is_subword(size)) w_next_state = ST_RMW;
          else                  w_we         = 1'b1;
        end
      end
      ST_RMW: begin
        w_next_state = ST_IDLE;
        w_we         = 1'b1;
        w_wr_idx     = r_idx;
        w_wr_data    = w_merged;
        w_wr_be      = w_lane_be;
      end
      default: w_next_state = ST_IDLE;
    endcase
    // Reset wins over any pending write, which is what aborts an in-flight merge.
    if (rst) begin
      w_we         = 1'b0;
      w_next_state = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so the pipeline samples the pre-edge array word (read-before-write).
    if (rst) begin
      r_state <= ST_IDLE;
      r_rd_q1 <= RESET_RDATA;
      r_rd_q2 <= RESET_RDATA;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE) begin
        r_rd_q1 <= r_mem[w_idx];
        r_rd_q2 <= r_rd_q1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && mem_write && is_subword(size)) begin
      r_idx   <= w_idx;
      r_lane  <= addr[1:0];
      r_size  <= size;
      r_wdata <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_wr_be[k]) r_mem[w_wr_idx][8*k +: 8] <= w_wr_data[8*k +: 8];
      end
    end
  end

  assign rdata = r_rd_q2;
  assign busy  = (r_state == ST_RMW);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a per-cycle vector table for the pipeline
// and store paths, then hand sequences for reset and reset-during-RMW.
module tb_mem_responder;
  import mem_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic        chk_rd;     // 0 where rdata holds a never-written word
    logic [31:0] exp_rdata;
    logic        exp_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        mem_write, busy;
  logic [1:0]  size;

  int n_checks = 0;
  int n_errors = 0;

  vec_t vecs[$];

  mem_responder #(.DEPTH_LOG2(8), .RESET_RDATA(32'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .mem_write (mem_write),
    .size      (size),
    .rdata     (rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w,
                       input logic [1:0] s);
    addr      = a;
    wdata     = d;
    mem_write = w;
    size      = s;
  endtask

  function automatic vec_t v(input logic [31:0] a, input logic [31:0] d, input logic w,
                             input logic [1:0] s, input logic c, input logic [31:0] er,
                             input logic eb);
    vec_t t;
    t.addr = a; t.wdata = d; t.we = w; t.size = s;
    t.chk_rd = c; t.exp_rdata = er; t.exp_busy = eb;
    return t;
  endfunction

  initial begin
    // Each row is driven for one cycle; expectations are the outputs right after that edge.
    vecs.push_back(v(32'h000, 32'h12345678, 1, SZ_WORD, 1, 32'h0,        0)); // preload 0x0
    vecs.push_back(v(32'h000, 32'h0,        0, SZ_WORD, 0, 32'h0,        0)); // read 0x0
    vecs.push_back(v(32'h000, 32'h0,        0, SZ_WORD, 1, 32'h12345678, 0));
    vecs.push_back(v(32'h000, 32'h0000000A, 1, SZ_WORD, 1, 32'h12345678, 0)); // store, old word captured
    vecs.push_back(v(32'h004, 32'h0000000B, 1, SZ_WORD, 1, 32'h12345678, 0));
    vecs.push_back(v(32'h008, 32'h0000000C, 1, SZ_WORD, 0, 32'h0,        0));
    vecs.push_back(v(32'h020, 32'hCAFEF00D, 1, SZ_WORD, 0, 32'h0,        0));
    vecs.push_back(v(32'h000, 32'h0,        0, SZ_WORD, 0, 32'h0,        0)); // pipelined reads
    vecs.push_back(v(32'h004, 32'h0,        0, SZ_WORD, 1, 32'h0000000A, 0));
    vecs.push_back(v(32'h008, 32'h0,        0, SZ_WORD, 1, 32'h0000000B, 0));
    vecs.push_back(v(32'h010, 32'hDEADBEEF, 1, SZ_WORD, 1, 32'h0000000C, 0)); // word store
    vecs.push_back(v(32'h010, 32'h0,        0, SZ_WORD, 0, 32'h0,        0)); // load next cycle
    vecs.push_back(v(32'h010, 32'h0,        0, SZ_WORD, 1, 32'hDEADBEEF, 0));
    vecs.push_back(v(32'h012, 32'h00000055, 1, SZ_BYTE, 1, 32'hDEADBEEF, 1)); // byte store
    vecs.push_back(v(32'h020, 32'h00000000, 1, SZ_WORD, 1, 32'hDEADBEEF, 0)); // dropped while busy
    vecs.push_back(v(32'h010, 32'h0,        0, SZ_WORD, 1, 32'hDEADBEEF, 0));
    vecs.push_back(v(32'h010, 32'h00001234, 1, SZ_HALF, 1, 32'hDEAD55EF, 1)); // halfword store
    vecs.push_back(v(32'h020, 32'h0,        0, SZ_WORD, 1, 32'hDEAD55EF, 0));
    vecs.push_back(v(32'h010, 32'h0,        0, SZ_WORD, 1, 32'hDEAD55EF, 0));
    vecs.push_back(v(32'h020, 32'h0,        0, SZ_WORD, 1, 32'h123455EF, 0));
    vecs.push_back(v(32'h000, 32'h0,        0, SZ_WORD, 1, 32'hCAFEF00D, 0)); // 0x20 untouched
    vecs.push_back(v(32'h400, 32'h11223344, 1, SZ_WORD, 1, 32'h0000000A, 0)); // aliases 0x0
    vecs.push_back(v(32'h000, 32'h0,        0, SZ_WORD, 1, 32'h0000000A, 0));
    vecs.push_back(v(32'h000, 32'h0,        0, SZ_WORD, 1, 32'h11223344, 0));
    vecs.push_back(v(32'h024, 32'h87654321, 1, 2'd3,    1, 32'h11223344, 0)); // size 3 = word
    vecs.push_back(v(32'h024, 32'h0,        0, SZ_WORD, 0, 32'h0,        0));
    vecs.push_back(v(32'h024, 32'h0,        0, SZ_WORD, 1, 32'h87654321, 0));

    rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0, SZ_WORD);
    tick();
    tick();
    rst = 1'b0;
    check("reset_rdata", rdata, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].size);
      tick();
      check($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].exp_busy});
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
    end

    // Reset in the RMW cycle must abort the merge and clear the pipeline.
    drive(32'h001, 32'h000000FF, 1'b1, SZ_BYTE);
    tick();
    check("abort_busy_set", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    drive(32'h0, 32'h0, 1'b0, SZ_WORD);
    tick();
    check("abort_busy_clr", {31'h0, busy}, 32'h0);
    check("abort_rdata_reset", rdata, 32'h0);
    rst = 1'b0;
    tick();
    tick();
    check("abort_word_kept", rdata, 32'h11223344);

    // Byte lane 3 merge, then a word read back.
    drive(32'h007, 32'h000000EE, 1'b1, SZ_BYTE);
    tick();
    check("lane3_busy", {31'h0, busy}, 32'h1);
    drive(32'h004, 32'h0, 1'b0, SZ_WORD);
    tick();
    check("lane3_busy_one_cycle", {31'h0, busy}, 32'h0);
    tick();
    tick();
    check("lane3_merged", rdata, 32'h000000EE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
